// File: rtl/svm_pkg.sv
// Shared types and constants for the SVM engine and its input feeder.
// Exports feature-vector typedef and the feeder FSM state encoding.
package svm_pkg;

  localparam int DATA_SIZE  = 32;
  localparam int NUM_FEAT   = 2;
  localparam int NUM_SV     = 3;
  localparam int ACCUM_SIZE = 2 * DATA_SIZE + 8;

  typedef logic [NUM_FEAT-1:0][DATA_SIZE-1:0] feat_vec_t;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN
  } feed_state_t;

endpackage

// File: rtl/svm_vec_fifo.sv
// Synchronous FIFO of {vector, last} with occupancy and last-flag count.
// Ports: i_push/i_vec/i_last in, i_pop in, o_vec/o_last head, o_full,
// o_empty, o_count, o_last_cnt.
module svm_vec_fifo #(
  parameter int DATA_SIZE  = 32,
  parameter int NUM_FEAT   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_push,
  input  logic [NUM_FEAT-1:0][DATA_SIZE-1:0] i_vec,
  input  logic                               i_last,
  input  logic                               i_pop,
  output logic [NUM_FEAT-1:0][DATA_SIZE-1:0] o_vec,
  output logic                               o_last,
  output logic                               o_full,
  output logic                               o_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_count,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_last_cnt
);

  import svm_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic [NUM_FEAT-1:0][DATA_SIZE-1:0] r_vec [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]              r_last;
  logic [AW-1:0]                      r_wr;
  logic [AW-1:0]                      r_rd;
  logic [CW-1:0]                      r_count;
  logic [CW-1:0]                      r_last_cnt;
  logic                               w_push;
  logic                               w_pop;
  logic                               w_pop_last;

  assign o_full     = (r_count == CW'(FIFO_DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_last_cnt = r_last_cnt;
  assign o_vec      = r_vec[r_rd];
  assign o_last     = r_last[r_rd];

  assign w_push     = i_push && !o_full;
  assign w_pop      = i_pop && !o_empty;
  assign w_pop_last = w_pop && r_last[r_rd];

  // Payload storage needs no reset; only valid entries are ever read.
  always_ff @(posedge clk) begin
    if (w_push) r_vec[r_wr] <= i_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last     <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_last_cnt <= '0;
    end else begin
      if (w_push) begin
        r_last[r_wr] <= i_last;
        r_wr         <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_push)
                         - CW'(w_pop);
      r_last_cnt <= r_last_cnt
                  + CW'(w_push && i_last)
                  - CW'(w_pop_last);
    end
  end

endmodule

// File: rtl/svm_feeder.sv
// Buffers test vectors and drives hw_svm start/last_input/test_vector.
// Ports: in_valid/in_ready/in_vector/in_last upstream; start, last_input,
// test_vector, busy, underrun toward the engine.
module svm_feeder #(
  parameter int DATA_SIZE  = 32,
  parameter int NUM_FEAT   = 2,
  parameter int NUM_SV     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NUM_FEAT-1:0][DATA_SIZE-1:0] in_vector,
  input  logic                               in_last,
  output logic                               start,
  output logic                               last_input,
  output logic [NUM_FEAT-1:0][DATA_SIZE-1:0] test_vector,
  output logic                               busy,
  output logic                               underrun
);

  import svm_pkg::*;

  localparam int HW = (NUM_SV > 1) ? $clog2(NUM_SV) : 1;
  localparam int DW = $clog2(NUM_FEAT*NUM_SV+1);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int DRAIN_LEN = NUM_FEAT * NUM_SV;

  feed_state_t                        r_state;
  logic [HW-1:0]                      r_hold;
  logic [DW-1:0]                      r_drain;
  logic                               r_cur_last;
  logic                               r_lpend;
  logic                               r_start;
  logic                               r_last_input;
  logic                               r_underrun;
  logic [NUM_FEAT-1:0][DATA_SIZE-1:0] r_tv;

  logic [NUM_FEAT-1:0][DATA_SIZE-1:0] w_vec;
  logic                               w_last;
  logic                               w_full;
  logic                               w_empty;
  logic [CW-1:0]                      w_count;
  logic [CW-1:0]                      w_last_cnt;
  logic                               w_launch;
  logic                               w_hold_end;
  logic                               w_pop;
  logic                               w_push;

  svm_vec_fifo #(
    .DATA_SIZE  (DATA_SIZE),
    .NUM_FEAT   (NUM_FEAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_vec      (in_vector),
    .i_last     (in_last),
    .i_pop      (w_pop),
    .o_vec      (w_vec),
    .o_last     (w_last),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count),
    .o_last_cnt (w_last_cnt)
  );

  // Ready comes straight from the registered count.
  assign in_ready = (w_count != CW'(FIFO_DEPTH));
  assign w_push   = in_valid && in_ready;

  assign w_launch   = !w_empty &&
                      ((w_last_cnt != '0) || w_full);
  assign w_hold_end = (r_hold == HW'(NUM_SV-1));

  always_comb begin
    w_pop = 1'b0;
    unique case (r_state)
      IDLE:    w_pop = w_launch;
      FEED:    w_pop = w_hold_end && !r_cur_last
                       && !w_empty;
      default: w_pop = 1'b0;
    endcase
  end

  assign start       = r_start;
  assign last_input  = r_last_input;
  assign test_vector = r_tv;
  assign busy        = (r_state != IDLE);
  assign underrun    = r_underrun;

  // r_drain counts cycles since last_input; it reads 0 in that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_hold       <= '0;
      r_drain      <= '0;
      r_cur_last   <= 1'b0;
      r_lpend      <= 1'b0;
      r_start      <= 1'b0;
      r_last_input <= 1'b0;
      r_underrun   <= 1'b0;
      r_tv         <= '0;
    end else begin
      r_start      <= 1'b0;
      r_last_input <= 1'b0;
      if (r_drain != DW'(DRAIN_LEN))
        r_drain <= r_drain + 1'b1;
      unique case (r_state)
        IDLE: begin
          if (w_launch) begin
            r_state    <= FEED;
            r_tv       <= w_vec;
            r_cur_last <= w_last;
            r_lpend    <= w_last;
            r_hold     <= '0;
            r_start    <= 1'b1;
          end
        end
        FEED: begin
          // A one-vector batch flags last one cycle after start,
          // since the engine ignores last_input on its start cycle.
          if (r_lpend) begin
            r_lpend      <= 1'b0;
            r_last_input <= 1'b1;
            r_drain      <= '0;
          end
          if (w_hold_end) begin
            r_hold <= '0;
            if (r_cur_last) begin
              r_state <= DRAIN;
            end else if (!w_empty) begin
              r_tv         <= w_vec;
              r_cur_last   <= w_last;
              r_last_input <= w_last;
              if (w_last) r_drain <= '0;
            end else begin
              r_underrun <= 1'b1;
            end
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        DRAIN: begin
          if (r_drain >= DW'(DRAIN_LEN-1))
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_svm_feeder.sv
// Self-checking bench for svm_feeder (NUM_FEAT=2, NUM_SV=3, depth 4).
// Expected start/last_input events are queued as stimulus is driven.
module tb_svm_feeder;

  typedef logic [1:0][31:0] vec_t;

  typedef struct {
    int   cyc;
    logic st;
    logic li;
    vec_t vec;
  } exp_t;

  logic clk;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  vec_t in_vector;
  logic in_last;
  logic start;
  logic last_input;
  vec_t test_vector;
  logic busy;
  logic underrun;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  svm_feeder #(
    .DATA_SIZE  (32),
    .NUM_FEAT   (2),
    .NUM_SV     (3),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_vector   (in_vector),
    .in_last     (in_last),
    .start       (start),
    .last_input  (last_input),
    .test_vector (test_vector),
    .busy        (busy),
    .underrun    (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(int a, int b);
    return {32'(a), 32'(b)};
  endfunction

  task automatic do_reset();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_vector = '0;
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push(vec_t v, logic l);
    in_valid  = 1'b1;
    in_vector = v;
    in_last   = l;
  endtask

  task automatic test_reset();
    exp_t e;
    do_reset();
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (start || last_input) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL rst_pulse k=%0d got st=%b li=%b want none",
                   k, start, last_input);
        end else begin
          e = sbq.pop_front();
          if (k !== e.cyc || start !== e.st ||
              last_input !== e.li || test_vector !== e.vec) begin
            bad++;
            $display("FAIL rst_event k=%0d got st=%b li=%b v=%h want k=%0d st=%b li=%b v=%h",
                     k, start, last_input, test_vector,
                     e.cyc, e.st, e.li, e.vec);
          end
        end
      end
      if (k == 0) begin
        total++;
        if ({start, last_input, busy, underrun} !== 4'b0) begin
          bad++;
          $display("FAIL rst_flags got=%b want=0000",
                   {start, last_input, busy, underrun});
        end
        total++;
        if (test_vector !== '0) begin
          bad++;
          $display("FAIL rst_tv got=%h want=0", test_vector);
        end
        total++;
        if (in_ready !== 1'b1) begin
          bad++;
          $display("FAIL rst_ready got=%b want=1", in_ready);
        end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (k == 0) begin
        push(mk(7, 8), 1'b1);
        sbq.push_back('{2, 1'b1, 1'b0, mk(7, 8)});
        sbq.push_back('{3, 1'b0, 1'b1, mk(7, 8)});
      end
      if (k == 3) begin
        rst_n = 1'b0;
        #1;
        total++;
        if ({start, last_input, busy, underrun} !== 4'b0 ||
            test_vector !== '0 || in_ready !== 1'b1) begin
          bad++;
          $display("FAIL rst_async got flags=%b v=%h rdy=%b want 0000/0/1",
                   {start, last_input, busy, underrun},
                   test_vector, in_ready);
        end
      end
      if (k == 5) rst_n = 1'b1;
      if (k == 10) begin
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL rst_idle busy got=%b want=0", busy);
        end
      end
    end
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL rst_missing got=%0d pending want=0", sbq.size());
    end
  endtask

  task automatic test_two_vec();
    exp_t e;
    vec_t w;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (start || last_input) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL two_pulse k=%0d got st=%b li=%b want none",
                   k, start, last_input);
        end else begin
          e = sbq.pop_front();
          if (k !== e.cyc || start !== e.st ||
              last_input !== e.li || test_vector !== e.vec) begin
            bad++;
            $display("FAIL two_event k=%0d got st=%b li=%b v=%h want k=%0d st=%b li=%b v=%h",
                     k, start, last_input, test_vector,
                     e.cyc, e.st, e.li, e.vec);
          end
        end
      end
      if (k >= 3 && k <= 8) begin
        w = (k < 6) ? mk(1, 2) : mk(3, 4);
        total++;
        if (test_vector !== w) begin
          bad++;
          $display("FAIL two_hold k=%0d got=%h want=%h",
                   k, test_vector, w);
        end
      end
      if (k == 11 || k == 12) begin
        total++;
        if (busy !== (k == 11)) begin
          bad++;
          $display("FAIL two_busy k=%0d got=%b want=%b",
                   k, busy, (k == 11));
        end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (k == 0) begin
        push(mk(1, 2), 1'b0);
        sbq.push_back('{3, 1'b1, 1'b0, mk(1, 2)});
      end
      if (k == 1) begin
        push(mk(3, 4), 1'b1);
        sbq.push_back('{6, 1'b0, 1'b1, mk(3, 4)});
      end
    end
    total++;
    if (sbq.size() != 0 || underrun !== 1'b0) begin
      bad++;
      $display("FAIL two_end got pend=%0d un=%b want 0/0",
               sbq.size(), underrun);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      if (start || last_input) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL b2b_pulse k=%0d got st=%b li=%b want none",
                   k, start, last_input);
        end else begin
          e = sbq.pop_front();
          if (k !== e.cyc || start !== e.st ||
              last_input !== e.li || test_vector !== e.vec) begin
            bad++;
            $display("FAIL b2b_event k=%0d got st=%b li=%b v=%h want k=%0d st=%b li=%b v=%h",
                     k, start, last_input, test_vector,
                     e.cyc, e.st, e.li, e.vec);
          end
        end
      end
      if (k == 12 || k == 21 || k == 22) begin
        total++;
        if (busy !== (k == 21)) begin
          bad++;
          $display("FAIL b2b_busy k=%0d got=%b want=%b",
                   k, busy, (k == 21));
        end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      unique case (k)
        0: begin
          push(mk(11, 12), 1'b0);
          sbq.push_back('{3, 1'b1, 1'b0, mk(11, 12)});
        end
        1: begin
          push(mk(13, 14), 1'b1);
          sbq.push_back('{6, 1'b0, 1'b1, mk(13, 14)});
        end
        2: begin
          push(mk(15, 16), 1'b0);
          sbq.push_back('{13, 1'b1, 1'b0, mk(15, 16)});
        end
        3: begin
          push(mk(17, 18), 1'b1);
          sbq.push_back('{16, 1'b0, 1'b1, mk(17, 18)});
        end
        default: ;
      endcase
    end
    total++;
    if (sbq.size() != 0 || underrun !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end got pend=%0d un=%b want 0/0",
               sbq.size(), underrun);
    end
  endtask

  task automatic test_one_vec();
    exp_t e;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (start || last_input) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL one_pulse k=%0d got st=%b li=%b want none",
                   k, start, last_input);
        end else begin
          e = sbq.pop_front();
          if (k !== e.cyc || start !== e.st ||
              last_input !== e.li || test_vector !== e.vec) begin
            bad++;
            $display("FAIL one_event k=%0d got st=%b li=%b v=%h want k=%0d st=%b li=%b v=%h",
                     k, start, last_input, test_vector,
                     e.cyc, e.st, e.li, e.vec);
          end
        end
      end
      if (k == 8 || k == 9 || k == 16 || k == 17) begin
        total++;
        if (busy !== (k == 8 || k == 16)) begin
          bad++;
          $display("FAIL one_busy k=%0d got=%b want=%b",
                   k, busy, (k == 8 || k == 16));
        end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (k == 0) begin
        push(mk(7, 8), 1'b1);
        sbq.push_back('{2, 1'b1, 1'b0, mk(7, 8)});
        sbq.push_back('{3, 1'b0, 1'b1, mk(7, 8)});
      end
      if (k == 4) begin
        push(mk(5, 6), 1'b1);
        sbq.push_back('{10, 1'b1, 1'b0, mk(5, 6)});
        sbq.push_back('{11, 1'b0, 1'b1, mk(5, 6)});
      end
    end
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL one_missing got=%0d pending want=0", sbq.size());
    end
  endtask

  task automatic test_underrun();
    exp_t e;
    vec_t w;
    do_reset();
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (start || last_input) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL und_pulse k=%0d got st=%b li=%b want none",
                   k, start, last_input);
        end else begin
          e = sbq.pop_front();
          if (k !== e.cyc || start !== e.st ||
              last_input !== e.li || test_vector !== e.vec) begin
            bad++;
            $display("FAIL und_event k=%0d got st=%b li=%b v=%h want k=%0d st=%b li=%b v=%h",
                     k, start, last_input, test_vector,
                     e.cyc, e.st, e.li, e.vec);
          end
        end
      end
      if (k == 4) begin
        total++;
        if (in_ready !== 1'b0) begin
          bad++;
          $display("FAIL und_full ready got=%b want=0", in_ready);
        end
      end
      if (k == 8 || k == 11 || k == 14 ||
          k == 16 || k == 17 || k == 19) begin
        w = mk(20 + (k - 5) / 3, 30 + (k - 5) / 3);
        if (k > 16) w = mk(23, 33);
        total++;
        if (test_vector !== w) begin
          bad++;
          $display("FAIL und_hold k=%0d got=%h want=%h",
                   k, test_vector, w);
        end
      end
      if (k == 16 || k == 17) begin
        total++;
        if (underrun !== (k == 17)) begin
          bad++;
          $display("FAIL und_flag k=%0d got=%b want=%b",
                   k, underrun, (k == 17));
        end
      end
      if (k == 25 || k == 26) begin
        total++;
        if (busy !== (k == 25)) begin
          bad++;
          $display("FAIL und_busy k=%0d got=%b want=%b",
                   k, busy, (k == 25));
        end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (k < 4) push(mk(20 + k, 30 + k), 1'b0);
      if (k == 0)
        sbq.push_back('{5, 1'b1, 1'b0, mk(20, 30)});
      if (k == 17) begin
        push(mk(9, 9), 1'b1);
        sbq.push_back('{20, 1'b0, 1'b1, mk(9, 9)});
      end
    end
    total++;
    if (sbq.size() != 0 || underrun !== 1'b1) begin
      bad++;
      $display("FAIL und_end got pend=%0d un=%b want 0/1",
               sbq.size(), underrun);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    vec_t w;
    int   idx;
    idx = 0;
    do_reset();
    for (int k = 0; k < 46; k++) begin
      @(negedge clk);
      if (start || last_input) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL bp_pulse k=%0d got st=%b li=%b want none",
                   k, start, last_input);
        end else begin
          e = sbq.pop_front();
          if (k !== e.cyc || start !== e.st ||
              last_input !== e.li || test_vector !== e.vec) begin
            bad++;
            $display("FAIL bp_event k=%0d got st=%b li=%b v=%h want k=%0d st=%b li=%b v=%h",
                     k, start, last_input, test_vector,
                     e.cyc, e.st, e.li, e.vec);
          end
        end
      end
      if (k == 4) begin
        total++;
        if (in_ready !== 1'b0) begin
          bad++;
          $display("FAIL bp_ready got=%b want=0", in_ready);
        end
      end
      if (k == 8 || k == 11 || k == 14) begin
        w = mk(40 + (k - 5) / 3, 50 + (k - 5) / 3);
        total++;
        if (test_vector !== w) begin
          bad++;
          $display("FAIL bp_order k=%0d got=%h want=%h",
                   k, test_vector, w);
        end
      end
      if (k == 40) begin
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
          bad++;
          $display("FAIL bp_post got busy=%b rdy=%b want 0/1",
                   busy, in_ready);
        end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (k < 24 && idx < 5) begin
        push(mk(40 + idx, 50 + idx), idx == 4);
        if (in_ready) begin
          if (idx == 0)
            sbq.push_back('{5, 1'b1, 1'b0, mk(40, 50)});
          if (idx == 4)
            sbq.push_back('{17, 1'b0, 1'b1, mk(44, 54)});
          idx++;
        end
      end
      if (k >= 24 && k < 28)
        push(mk(60 + k, 70 + k), 1'b0);
      if (k == 24)
        sbq.push_back('{29, 1'b1, 1'b0, mk(84, 94)});
      if (k == 31) begin
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if ({start, last_input, busy, underrun} !== 4'b0 ||
            test_vector !== '0 || in_ready !== 1'b1) begin
          bad++;
          $display("FAIL bp_rst got flags=%b v=%h rdy=%b want 0000/0/1",
                   {start, last_input, busy, underrun},
                   test_vector, in_ready);
        end
      end
      if (k == 33) rst_n = 1'b1;
    end
    total++;
    if (sbq.size() != 0 || idx != 5) begin
      bad++;
      $display("FAIL bp_end got pend=%0d acc=%0d want 0/5",
               sbq.size(), idx);
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_vector = '0;
    test_reset();
    test_two_vec();
    test_back_to_back();
    test_one_vec();
    test_underrun();
    test_backpressure();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
